// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states and the
// bundled pipeline-register control word.
package pipeline_hazard_controller_pkg;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      LOAD_BUBBLE = 2'd1,
      MEM_WAIT    = 2'd2
   } hazard_state_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_flush;
      logic exmem_en;
      logic memwb_flush;
   } pipe_ctrl_t;

   // Field order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush
   localparam pipe_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam pipe_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam pipe_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   // A load in EX whose destination feeds any operand ID actually reads.
   function automatic logic load_use_hazard(
      input logic       id_valid,
      input logic       ex_valid,
      input logic       ex_memrd,
      input logic [3:0] id_rs,
      input logic [3:0] id_rx,
      input logic [3:0] id_rd,
      input logic       id_uses_rx,
      input logic       id_uses_rd,
      input logic [3:0] ex_rd
   );
      logic match;
      match = (id_rs == ex_rd) ||
              (id_uses_rx && (id_rx == ex_rd)) ||
              (id_uses_rd && (id_rd == ex_rd));
      return id_valid && ex_valid && ex_memrd && match;
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = W'(1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      if (inc_i && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// squash, memory-wait freeze with timeout, and stall/flush performance counters.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int LOAD_STALL  = 1,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_valid_i,
   input  logic [3:0]       id_rs_i,
   input  logic [3:0]       id_rx_i,
   input  logic [3:0]       id_rd_i,
   input  logic             id_uses_rx_i,
   input  logic             id_uses_rd_i,
   input  logic             id_branch_i,
   input  logic             ex_valid_i,
   input  logic             ex_memrd_i,
   input  logic [3:0]       ex_rd_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             pc_en_o,
   output logic             ifid_en_o,
   output logic             ifid_flush_o,
   output logic             idex_en_o,
   output logic             idex_flush_o,
   output logic             exmem_en_o,
   output logic             memwb_flush_o,
   output logic             mem_error_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int                WAIT_W      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_ZERO   = WAIT_W'(0);
   localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [2:0]        BUBBLE_INIT = 3'(LOAD_STALL - 1);

   hazard_state_t     state_q;
   hazard_state_t     state_d;
   logic [2:0]        bubble_q;
   logic [2:0]        bubble_d;
   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_d;
   logic              mem_error_q;
   logic              mem_error_d;
   pipe_ctrl_t        ctrl_s;
   logic              lu_s;
   logic              mw_s;
   logic              flush_inc_s;
   logic              stall_inc_s;

   assign lu_s = load_use_hazard(id_valid_i, ex_valid_i, ex_memrd_i, id_rs_i, id_rx_i,
                                 id_rd_i, id_uses_rx_i, id_uses_rd_i, ex_rd_i);
   assign mw_s = mem_req_i && !mem_ack_i;

   always_comb begin
      state_d     = state_q;
      bubble_d    = bubble_q;
      wait_d      = wait_q;
      mem_error_d = mem_error_q;
      ctrl_s      = CTRL_RUN;
      flush_inc_s = 1'b0;
      if (rst_i) begin
         ctrl_s = CTRL_RESET;
      end else begin
         case (state_q)
            RUN: begin
               if (mw_s) begin
                  ctrl_s  = CTRL_FREEZE;
                  state_d = MEM_WAIT;
                  wait_d  = WAIT_ONE;
               end else if (lu_s) begin
                  ctrl_s = CTRL_STALL;
                  if (LOAD_STALL > 1) begin
                     state_d  = LOAD_BUBBLE;
                     bubble_d = BUBBLE_INIT;
                  end else begin
                     state_d = RUN;
                  end
               end else if (id_branch_i && id_valid_i) begin
                  ctrl_s      = CTRL_BRANCH;
                  flush_inc_s = 1'b1;
               end else begin
                  ctrl_s = CTRL_RUN;
               end
            end
            LOAD_BUBBLE: begin
               if (mw_s) begin
                  ctrl_s   = CTRL_FREEZE;
                  state_d  = MEM_WAIT;
                  wait_d   = WAIT_ONE;
                  bubble_d = 3'd0;
               end else if (bubble_q == 3'd1) begin
                  ctrl_s   = CTRL_STALL;
                  state_d  = RUN;
                  bubble_d = 3'd0;
               end else begin
                  ctrl_s   = CTRL_STALL;
                  bubble_d = bubble_q - 3'd1;
               end
            end
            MEM_WAIT: begin
               if (mem_ack_i) begin
                  ctrl_s  = CTRL_RUN;
                  state_d = RUN;
                  wait_d  = WAIT_ZERO;
               end else if (wait_q == WAIT_LAST) begin
                  // Timeout: release as if acked and latch the error.
                  ctrl_s      = CTRL_RUN;
                  state_d     = RUN;
                  wait_d      = WAIT_ZERO;
                  mem_error_d = 1'b1;
               end else begin
                  ctrl_s = CTRL_FREEZE;
                  wait_d = wait_q + WAIT_ONE;
               end
            end
            default: begin
               ctrl_s   = CTRL_FREEZE;
               state_d  = RUN;
               wait_d   = WAIT_ZERO;
               bubble_d = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         bubble_q    <= 3'd0;
         wait_q      <= WAIT_ZERO;
         mem_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bubble_q    <= bubble_d;
         wait_q      <= wait_d;
         mem_error_q <= mem_error_d;
      end
   end

   assign stall_inc_s = !ctrl_s.pc_en && !rst_i;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (stall_inc_s),
      .count_o (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (flush_inc_s),
      .count_o (flush_cnt_o)
   );

   assign pc_en_o       = ctrl_s.pc_en;
   assign ifid_en_o     = ctrl_s.ifid_en;
   assign ifid_flush_o  = ctrl_s.ifid_flush;
   assign idex_en_o     = ctrl_s.idex_en;
   assign idex_flush_o  = ctrl_s.idex_flush;
   assign exmem_en_o    = ctrl_s.exmem_en;
   assign memwb_flush_o = ctrl_s.memwb_flush;
   assign mem_error_o   = mem_error_q;

endmodule
